// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sseg_pkg
// Purpose  : Shared constants for the seven-segment scan engine: digit count,
//            active-low "all off" patterns and the hex-to-segment table.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  // Display pins are active-low, so "everything off" is all ones.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Segment patterns {g,f,e,d,c,b,a}, active-low, indexed by nibble value.
  // Element 0 is the rightmost entry of the concatenation.
  localparam logic [15:0][6:0] SSEG_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage
`default_nettype wire

// File: rtl/sseg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_driver_if
// Purpose  : Load handshake bundle between a value producer and the scan
//            engine.
// Ports    : value_i     16-bit value, four hex nibbles (digit 0 rightmost)
//            dp_i        per-digit decimal point, 1 = lit
//            blank_lz_i  1 = blank leading zeros
//            load_valid  producer presents value_i/dp_i/blank_lz_i
//            load_ready  consumer staging register is empty
//            modport master = producer, modport slave = scan engine
// Revision : 1.0  initial release
// ============================================================================
interface sseg_scan_driver_if;
  import sseg_pkg::*;

  logic [4*NUM_DIGITS-1:0] value_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic                    blank_lz_i;
  logic                    load_valid;
  logic                    load_ready;

  modport master (
    output value_i,
    output dp_i,
    output blank_lz_i,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  value_i,
    input  dp_i,
    input  blank_lz_i,
    input  load_valid,
    output load_ready
  );

endinterface
`default_nettype wire

// File: rtl/sseg_scan_driver_hex_to_sseg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_sseg
// Purpose  : Combinational nibble to seven-segment decoder (hex 0-F).
// Ports    : nibble  input  4  value to show
//            seg     output 7  segments {g,f,e,d,c,b,a}, active-low
// Revision : 1.0  initial release
// ============================================================================
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SSEG_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_driver
// Purpose  : Time-multiplexed 4-digit seven-segment scan engine with a
//            prescaled slot timer, anode dead time at the start of every
//            slot, optional leading-zero blanking and a frame-aligned
//            double-buffered value load.
// Ports    : clk         system clock, rising edge
//            rst_n       asynchronous active-low reset
//            load_if     load handshake (slave side)
//            an          anode enables, active-low, one-hot-low when driving
//            seg         segments {g,f,e,d,c,b,a}, active-low
//            dp          decimal point, active-low
//            frame_tick  one-cycle pulse on each digit 3->0 wrap
// Revision : 1.0  initial release
// ============================================================================
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int CLK_HZ       = 100000000,
  parameter int SLOT_HZ      = 4000,
  parameter int BLANK_CYCLES = 64   // must be 1 .. DIV-1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sseg_scan_driver_if.slave     load_if,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  // Clocks per digit slot; the slot counter must hold 0 .. DIV-1.
  localparam int                 c_DIV      = CLK_HZ / SLOT_HZ;
  localparam int                 c_CNT_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_BLANK    = c_CNT_W'(BLANK_CYCLES);

  // Scan position.
  logic [c_CNT_W-1:0]      r_cnt;
  logic [1:0]              r_idx;

  // Staging (written by the handshake) and display (read by the scan).
  logic                    r_stage_full;
  logic [4*NUM_DIGITS-1:0] r_stage_value;
  logic [NUM_DIGITS-1:0]   r_stage_dp;
  logic                    r_stage_lz;
  logic [4*NUM_DIGITS-1:0] r_disp_value;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic                    r_disp_lz;

  // Registered outputs.
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_tick;

  logic                    w_slot_end;
  logic                    w_frame_wrap;
  logic                    w_capture;
  logic                    w_commit;
  logic                    w_in_blank;
  logic [3:0]              w_nibble;
  logic [6:0]              w_dec_seg;
  logic                    w_zero_above;
  logic [NUM_DIGITS-1:0]   w_lz_blank;

  assign w_slot_end   = (r_cnt == c_CNT_LAST);
  assign w_frame_wrap = w_slot_end && (r_idx == 2'(NUM_DIGITS - 1));
  assign w_in_blank   = (r_cnt < c_BLANK);

  // Ready is a pure register output, so nothing on the load side can
  // reach the outputs combinationally.  Capture and commit are mutually
  // exclusive: capture needs an empty stage, commit needs a full one.
  assign w_capture = load_if.load_valid && !r_stage_full;
  assign w_commit  = w_frame_wrap && r_stage_full;

  assign load_if.load_ready = !r_stage_full;

  // ---------------------------------------------------------------------
  // Slot prescaler and digit index
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Staging / display double buffer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_full  <= 1'b0;
      r_stage_value <= '0;
      r_stage_dp    <= '0;
      r_stage_lz    <= 1'b0;
      r_disp_value  <= '0;
      r_disp_dp     <= '0;
      r_disp_lz     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_stage_full  <= 1'b1;
        r_stage_value <= load_if.value_i;
        r_stage_dp    <= load_if.dp_i;
        r_stage_lz    <= load_if.blank_lz_i;
      end else if (w_commit) begin
        r_stage_full  <= 1'b0;
        r_disp_value  <= r_stage_value;
        r_disp_dp     <= r_stage_dp;
        r_disp_lz     <= r_stage_lz;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Digit select, decode and leading-zero detection
  // ---------------------------------------------------------------------
  assign w_nibble = r_disp_value[{r_idx, 2'b00} +: 4];

  hex_to_sseg u_hex_to_sseg (
    .nibble (w_nibble),
    .seg    (w_dec_seg)
  );

  // Walk from the most significant digit down: a digit is a leading zero
  // when it and every digit above it are zero.  Digit 0 always shows.
  always_comb begin
    w_zero_above = 1'b1;
    w_lz_blank   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_above  = w_zero_above && (r_disp_value[4*k +: 4] == 4'h0);
      w_lz_blank[k] = w_zero_above && (k != 0);
    end
  end

  // ---------------------------------------------------------------------
  // Output registers: one cycle behind the scan position
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_wrap;
      if (w_in_blank) begin
        // Dead time: all anodes off so the previous digit cannot ghost.
        r_an  <= AN_OFF;
        r_seg <= SEG_OFF;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(NUM_DIGITS'(1) << r_idx);
        r_seg <= (r_disp_lz && w_lz_blank[r_idx]) ? SEG_OFF : w_dec_seg;
        r_dp  <= ~r_disp_dp[r_idx];
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_driver
// Purpose  : Self-checking bench for sseg_scan_driver with DIV=8 and
//            BLANK_CYCLES=2.  A time-based reference model predicts every
//            output each cycle from the cycle count since reset and the
//            frame-aligned load rule.
// Revision : 1.0  initial release
// ============================================================================
module tb_sseg_scan_driver;

  localparam int CLK_HZ  = 32000;
  localparam int SLOT_HZ = 4000;
  localparam int BLANK   = 2;
  localparam int DIV     = CLK_HZ / SLOT_HZ;
  localparam int FRAME   = 4 * DIV;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  sseg_scan_driver_if bus ();

  sseg_scan_driver #(
    .CLK_HZ       (CLK_HZ),
    .SLOT_HZ      (SLOT_HZ),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_if    (bus),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ticks_seen = 0;

  // Reference model state: cycles elapsed since reset release, plus the
  // staged and displayed contents.
  int          mk;
  logic [15:0] m_val,  m_sval;
  logic [3:0]  m_dp,   m_sdp;
  logic        m_lz,   m_slz;
  logic        m_full;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;  4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;  4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  task automatic model_reset();
    mk = 0;
    m_val = '0; m_dp = '0; m_lz = 1'b0;
    m_sval = '0; m_sdp = '0; m_slz = 1'b0;
    m_full = 1'b0;
  endtask

  // One clock: predict the outputs from the pre-edge scan position, apply
  // the load rule for this edge, then sample and compare after the edge.
  task automatic step();
    int         cnt, idx;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_tick;
    cnt = mk % DIV;
    idx = (mk / DIV) % 4;
    if (cnt < BLANK) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = 4'hF & ~(4'(1) << idx);
      e_seg = (m_lz && idx > 0 && (m_val >> (4 * idx)) == 16'h0) ? 7'h7F
              : hex7(m_val[4*idx +: 4]);
      e_dp  = ~m_dp[idx];
    end
    e_tick = ((mk % FRAME) == FRAME - 1);
    if (e_tick && m_full) begin
      m_val = m_sval; m_dp = m_sdp; m_lz = m_slz; m_full = 1'b0;
    end else if (bus.load_valid && !m_full) begin
      m_sval = bus.value_i; m_sdp = bus.dp_i; m_slz = bus.blank_lz_i;
      m_full = 1'b1;
    end
    mk++;
    @(posedge clk);
    #1;
    if (frame_tick) ticks_seen++;
    check_eq("an",    32'(an),             32'(e_an));
    check_eq("seg",   32'(seg),            32'(e_seg));
    check_eq("dp",    32'(dp),             32'(e_dp));
    check_eq("tick",  32'(frame_tick),     32'(e_tick));
    check_eq("ready", 32'(bus.load_ready), 32'(!m_full));
  endtask

  task automatic load_one(input logic [15:0] v, input logic [3:0] d,
                          input logic lz);
    bus.value_i = v; bus.dp_i = d; bus.blank_lz_i = lz; bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_an"},    32'(an),             32'hF);
    check_eq({tag, "_seg"},   32'(seg),            32'h7F);
    check_eq({tag, "_dp"},    32'(dp),             32'h1);
    check_eq({tag, "_tick"},  32'(frame_tick),     32'h0);
    check_eq({tag, "_ready"}, 32'(bus.load_ready), 32'h1);
  endtask

  initial begin
    int t0;
    bit found;
    bus.value_i = '0; bus.dp_i = '0; bus.blank_lz_i = 1'b0;
    bus.load_valid = 1'b0;
    model_reset();

    // Power-on reset.
    #2 rst_n = 1'b0;
    #2 check_reset_outputs("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: display register is 0, so DRIVE shows "0" everywhere.
    t0 = ticks_seen;
    repeat (4 * FRAME) step();
    check_eq("tick_count", 32'(ticks_seen - t0), 32'd4);

    // Mid-frame load with a decimal point on digit 2.
    repeat (5) step();
    load_one(16'h12A3, 4'b0100, 1'b0);
    repeat (2 * FRAME) step();

    // Leading-zero blanking, then an all-zero value.
    load_one(16'h0005, 4'b0000, 1'b1);
    repeat (2 * FRAME) step();
    load_one(16'h0000, 4'b0001, 1'b1);
    repeat (2 * FRAME) step();

    // Backpressure: value changes while the stage is full.
    bus.value_i = 16'h1111; bus.dp_i = 4'h0; bus.blank_lz_i = 1'b0;
    bus.load_valid = 1'b1;
    step();
    bus.value_i = 16'h2222;
    repeat (3 * FRAME) step();
    bus.load_valid = 1'b0;
    repeat (FRAME) step();

    // Asynchronous reset while digit 2 is being driven.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (an == 4'hB) found = 1'b1;
    end
    check_eq("find_an_b", 32'(found), 32'h1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2 * FRAME) step();

    // Back-to-back loads one frame apart.
    for (int f = 0; f < 6; f++) begin
      load_one(16'($urandom), 4'($urandom), 1'($urandom));
      repeat (FRAME - 1) step();
    end
    repeat (FRAME) step();

    // Random traffic, biased toward small values to exercise blanking.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] mask;
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h00FF;
        2: mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      bus.value_i    = 16'($urandom) & mask;
      bus.dp_i       = 4'($urandom);
      bus.blank_lz_i = 1'($urandom);
      bus.load_valid = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
Time-multiplexed scan engine for the 4-digit seven-segment display. It sits directly downstream of the refresh counting stage and replaces a free-running 2-bit digit index with a prescaled, dead-time-protected scan. It drives active-low anodes, segments and decimal point. A new 16-bit value is accepted through a valid/ready handshake and committed only at a frame boundary, so a digit never shows a torn value.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
SLOT_HZ, 4000, digit-slot rate in Hz; DIV = CLK_HZ/SLOT_HZ clocks per slot; DIV >= 4 required
BLANK_CYCLES, 64, anode-off dead time at the start of each slot; must satisfy 1 <= BLANK_CYCLES < DIV

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
value_i  input  16  four hex nibbles; digit k = value_i[4k+3:4k], where digit 0 is rightmost
dp_i  input  4  decimal point per digit, 1 = lit
blank_lz_i  input  1  1 = blank leading zeros
load_valid  input  1  value_i, dp_i and blank_lz_i are presented
load_ready  output  1  staging register empty
an  output  4  anode enables, active-low, one-hot-low when driving
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
frame_tick  output  1  one-cycle pulse on each digit 3->0 wrap

Behaviour:
- Reset (asynchronous assert, synchronous release) sets the following:
  - an=4'hF, seg=7'h7F, dp=1, frame_tick=0, load_ready=1.
  - Prescaler cnt=0, digit idx=0.
  - Display register (value, dp, lz) = 0; staging register empty.
- Prescaler cnt counts 0..DIV-1. At cnt==DIV-1, cnt wraps to 0 and idx increments modulo 4 (3->0).
- Slot phases:
  - BLANK: cnt < BLANK_CYCLES.
  - DRIVE: cnt >= BLANK_CYCLES.
- Outputs are registered and show the (cnt, idx) state of the previous cycle (1-cycle latency).
  - In BLANK: an=4'hF, seg=7'h7F, dp=1.
  - In DRIVE: an = ~(1<<idx); seg = decode(nibble idx); dp = ~dp_reg[idx].
- Decode is hex 0-F. Examples: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 8=0x00, A=0x08, F=0x0E.
- Leading-zero blanking applies when lz_reg=1:
  - Digit k (k=3..1) is blanked if nibbles k..3 are all zero.
  - A blanked digit gives seg=7'h7F and its anode is still driven.
  - dp is unaffected by blanking.
  - Digit 0 is never blanked.
- Handshake:
  - Capture into staging on load_valid && load_ready; load_ready drops on the next edge.
  - Commit moves staging to the display register on the edge where idx wraps 3->0. It coincides with frame_tick being asserted for one cycle.
  - load_ready returns to 1 on the cycle after commit.
  - With load_ready=0, load_valid is ignored and the staged data is held.
  - A capture and a commit can never occur on the same edge, because ready is low whenever staging is full.
- frame_tick pulses exactly once per 4*DIV clocks, whether or not a commit occurs.
- Reset mid-scan forces outputs blank immediately (asynchronously) and discards staged data. Scanning restarts at idx=0, cnt=0.
- No combinational path exists from any input to any output.

Decomposition:
- Package sseg_pkg holds:
  - NUM_DIGITS=4.
  - Active-low constants SEG_OFF=7'h7F and AN_OFF=4'hF.
  - The 16-entry hex-to-segment constant table.
- Sub-module hex_to_sseg is a combinational nibble-to-7-segment decoder using the table. It is instantiated once, muxed by idx.
- The prescaler, handshake and leading-zero logic remain in the top.

Test Plan:
- Bench configuration for all scenarios: DIV=8, BLANK_CYCLES=2.
- Reset, then idle:
  - an=F for 2 cycles, then E for 6 cycles; then F for 2 cycles, then D, B, 7.
  - frame_tick high once per 32 clocks.
  - seg=0x40 throughout DRIVE.
- Load 16'h12A3 with dp_i=4'b0100 and lz=0 mid-frame:
  - load_ready=0 until the next frame_tick; load_ready=1 the cycle after.
  - In the next frame, seg = 0x30, 0x08, 0x24, 0x79 for digits 0..3.
  - dp=0 only while an=B.
- Load 16'h0005 with lz=1:
  - Digits 3..1 show seg=7F with their anodes active.
  - Digit 0 shows 0x12.
  - Load 16'h0000 with lz=1: digit 0 shows 0x40.
- Backpressure:
  - Hold load_valid=1 with value 16'h1111, then change to 16'h2222 while load_ready=0.
  - The display shows 1111 only; 2222 is captured after ready returns.
- Assert rst_n=0 while an=B mid-frame:
  - an=F and seg=7F in the same cycle, without waiting for a clock edge.
  - After release, the first DRIVE has an=E and the display register is 0.
- Back-to-back loads one frame apart:
  - Each value appears for exactly one full frame.
  - No frame mixes nibbles of two values (check seg against decode per idx).
